cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder that serves both the instruction and data channels issued by the custom CPU core.
- Backs a single word-addressed storage array. Each of the two channels has its own handshake FSM and fixed-latency counter.
- Used as the memory model in simulation and as on-chip memory in FPGA builds, so the core is exercised against real ready/valid back-pressure.

Parameters:
- ADDR_WIDTH, 12, word-address bits; storage is 2^ADDR_WIDTH x 32 bit.
- INST_LAT, 2, cycles from instruction-request acceptance to Inst_Valid; legal range 1..15.
- DATA_LAT, 2, cycles from read-request acceptance to Read_data_Valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- PC  in  32  instruction fetch byte address
- Inst_Req_Valid  in  1  fetch request valid
- Inst_Req_Ready  out  1  fetch request accepted when high with valid
- Instruction  out  32  fetched word
- Inst_Valid  out  1  fetched word valid
- Inst_Ready  in  1  core accepts fetched word
- Address  in  32  data byte address
- MemWrite  in  1  write request
- Write_data  in  32  write data
- Write_strb  in  4  byte enables; bit i covers bits 8i+7:8i
- MemRead  in  1  read request
- Mem_Req_Ready  out  1  data request accepted
- Read_data  out  32  read result
- Read_data_Valid  out  1  read result valid
- Read_data_Ready  in  1  core accepts read result

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values:
  - Inst_Req_Ready = 0, Mem_Req_Ready = 0, Inst_Valid = 0, Read_data_Valid = 0.
  - Instruction = 0, Read_data = 0.
  - Both FSMs in INIT. Storage contents are not reset.
- Per-channel FSM: INIT -> IDLE -> WAIT -> RESP -> IDLE.
  - INIT: lasts one cycle after rst deasserts.
  - IDLE: ready = 1. A request handshake (valid & ready) captures the word address, loads the latency counter with LAT-1 and moves to WAIT. If LAT == 1, it goes directly to RESP.
  - WAIT: ready = 0. The counter decrements each cycle; at 0 the FSM moves to RESP.
  - RESP: valid = 1, data held stable. On a response handshake it returns to IDLE. Ready rises the cycle after the handshake, so there is no same-cycle re-accept.
- Latency: a request accepted at cycle T produces valid at T+LAT. The output is registered.
- Read sampling:
  - The read value is taken from storage at acceptance cycle T and latched in a response register.
  - A later write to the same word does not alter an in-flight response (read-before-write).
- Addressing:
  - Word index = addr[ADDR_WIDTH+1:2].
  - Bits 1:0 are ignored. Higher bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2).
- Data writes:
  - Accepted in IDLE with MemWrite & Mem_Req_Ready. Storage is updated per Write_strb on that edge.
  - No response is produced. The data FSM stays in IDLE.
  - Write_strb = 0 is a no-op write that is still accepted.
- MemRead and MemWrite high together: treated as a write only; no read response.
- Instruction read and data write to the same word in the same cycle: the instruction returns the old word.
- Both channels are fully independent and may be in any state concurrently.
- rst asserted mid-operation: both FSMs go to INIT next edge. All valids/readys drop to 0 and any pending response is discarded.

Optional Feature:
- RESP_RAND_DELAY_EN defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advances every cycle.
  - At each request acceptance, LFSR[1:0] (instruction channel) or LFSR[3:2] (data channel) is added as 0..3 extra WAIT cycles.
- Undefined: latency is exactly INST_LAT / DATA_LAT.

Decomposition:
- Package cpu_mem_resp_pkg:
  - FSM state encoding (INIT, IDLE, WAIT, RESP).
  - Latency counter width constant (4).
  - LFSR seed and tap constants.
- Sub-module mem_resp_chan contains the FSM, latency counter and response register. It is instantiated twice (LAT = INST_LAT and LAT = DATA_LAT).
- Top level owns the storage array, write-strobe merge and LFSR.

Test Plan:
- Reset release: after rst high for 3 cycles, Inst_Req_Ready = 0 on the first cycle after release and 1 on the second; all valids stay 0.
- Fetch: preload word 4 = 32'h00A00093; PC = 32'h10 accepted at T -> Inst_Valid at T+2 with Instruction = 32'h00A00093; hold Inst_Ready = 0 for 3 cycles -> output stays stable.
- Byte write then read: write 32'hDEADBEEF to 32'h100 with strb 4'hF, then 32'h000000AA with strb 4'h1 -> read of 32'h100 returns 32'hDEADBEAA at acceptance+2.
- Hazard: accept read of 32'h200 (holding 32'h1) at T, write 32'h2 there at T+1 -> response is 32'h1; next read returns 32'h2.
- Aliasing: with ADDR_WIDTH = 12, write 32'h55 to 32'h4000 -> read of 32'h0 returns 32'h55.
- Reset mid-WAIT: assert rst one cycle after a read is accepted -> Read_data_Valid never rises; a new request after INIT completes normally.

Source files
------------

// File: rtl/cpu_mem_resp_pkg.sv
// Shared definitions for the CPU memory responder: per-channel FSM state
// encoding, latency counter sizing and the response-delay LFSR constants.
package cpu_mem_resp_pkg;

    // Handshake FSM states, shared by the instruction and data channels.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } chan_state_t;

    // Width of a latency parameter (1..15).
    localparam int LAT_W = 4;

    // The wait counter carries one extra bit so LAT-1 plus up to three
    // random extra cycles can never wrap.
    localparam int CNT_W = LAT_W + 1;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    // Polynomial terms 16,14,13,11 map onto register bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Next LFSR value: feedback enters at the MSB.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/mem_resp_chan.sv
// One request/response channel of the memory responder: handshake FSM
// (INIT -> IDLE -> WAIT -> RESP -> IDLE) and the fixed-latency counter.
// The response word itself is captured by the storage read register in the
// parent on the 'accept' pulse and stays stable until the next acceptance.
module mem_resp_chan
    import cpu_mem_resp_pkg::*;
#(
    parameter int LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    output logic       accept,
    input  logic [1:0] extra_wait,
    output logic       resp_valid,
    input  logic       resp_ready
);

    chan_state_t      state_reg;
    chan_state_t      state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] load_value;

    // Cycles still to spend in WAIT after acceptance; zero means go straight to RESP.
    assign load_value = CNT_W'(LAT - 1) + CNT_W'(extra_wait);

    assign accept = req_valid & req_ready;

    // State and counter registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state, counter and handshake outputs decoded from the current state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_next   = load_value;
                    state_next = (load_value == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The decrement to zero and the move to RESP happen on the same
                // edge, so valid appears exactly LAT cycles after acceptance.
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU core's instruction and data channels.
// Owns the word-addressed storage (one registered read port per channel,
// byte-strobed writes on the data port) and the optional response-delay LFSR.
// Optional feature macro: RESP_RAND_DELAY_EN adds 0..3 random WAIT cycles
// per accepted request; without it latency is exactly INST_LAT / DATA_LAT.
module cpu_mem_responder
    import cpu_mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int INST_LAT   = 2,
    parameter int DATA_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] inst_idx;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic                  data_rd_req;
    logic                  wr_en;
    logic [3:0]            lane_we;
    logic                  inst_accept;
    logic                  data_accept;
    logic [1:0]            inst_extra;
    logic [1:0]            data_extra;
    logic [31:0]           inst_word_reg;
    logic [31:0]           data_word_reg;
    logic                  unused_addr_bits;

    // Byte addresses alias modulo the storage size; the low two bits are ignored.
    assign inst_idx = PC[ADDR_WIDTH+1:2];
    assign data_idx = Address[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

    // A simultaneous read and write is a write only, so it never starts a read response.
    assign data_rd_req = MemRead & ~MemWrite;
    assign wr_en       = MemWrite & Mem_Req_Ready;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane_we
            assign lane_we[gi] = wr_en & Write_strb[gi];
        end
    endgenerate

`ifdef RESP_RAND_DELAY_EN
    logic [15:0] lfsr_reg;

    // Free-running LFSR that supplies the per-request random extra wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign inst_extra = lfsr_reg[1:0];
    assign data_extra = lfsr_reg[3:2];
`else
    assign inst_extra = 2'b00;
    assign data_extra = 2'b00;
`endif

    mem_resp_chan #(
        .LAT (INST_LAT)
    ) u_inst_chan (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (Inst_Req_Valid),
        .req_ready  (Inst_Req_Ready),
        .accept     (inst_accept),
        .extra_wait (inst_extra),
        .resp_valid (Inst_Valid),
        .resp_ready (Inst_Ready)
    );

    mem_resp_chan #(
        .LAT (DATA_LAT)
    ) u_data_chan (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (data_rd_req),
        .req_ready  (Mem_Req_Ready),
        .accept     (data_accept),
        .extra_wait (data_extra),
        .resp_valid (Read_data_Valid),
        .resp_ready (Read_data_Ready)
    );

    // Byte-strobed write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[data_idx][8*b +: 8] <= Write_data[8*b +: 8];
            end
        end
    end

    // Instruction read register: samples storage only on acceptance, so it holds
    // the response stable and sees the old word when a write hits the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_word_reg <= '0;
        end else if (inst_accept) begin
            inst_word_reg <= mem[inst_idx];
        end
    end

    // Data read register: captured at acceptance, so later writes to the same
    // word cannot disturb an in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_word_reg <= '0;
        end else if (data_accept) begin
            data_word_reg <= mem[data_idx];
        end
    end

    assign Instruction = inst_word_reg;
    assign Read_data   = data_word_reg;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed testbench for cpu_mem_responder: a table of write/read vectors
// plus hand-written sequences for reset, fetch hold, hazards and same-cycle cases.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cpu_mem_responder #(
        .ADDR_WIDTH (12),
        .INST_LAT   (2),
        .DATA_LAT   (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs [NVEC];

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_mem_ready(input string name);
        int k = 0;
        while (!Mem_Req_Ready && k < 20) begin
            tick();
            k++;
        end
        if (!Mem_Req_Ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: Mem_Req_Ready timeout, got 0, expected 1", name);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        Address    = addr;
        Write_data = data;
        Write_strb = strb;
        MemWrite   = 1'b1;
        wait_mem_ready("write_ready");
        tick();
        MemWrite = 1'b0;
        check("write_no_resp", {31'd0, Read_data_Valid}, 32'd0);
        $display("txn WR addr=%h data=%h strb=%h", addr, data, strb);
    endtask

    // Issue one read; returns data and the number of edges from acceptance to valid.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int lat);
        Address = addr;
        MemRead = 1'b1;
        wait_mem_ready("read_ready");
        tick();
        MemRead = 1'b0;
        lat = 1;
        while (!Read_data_Valid && lat < 20) begin
            tick();
            lat++;
        end
        data = Read_data;
        Read_data_Ready = 1'b1;
        tick();
        Read_data_Ready = 1'b0;
        $display("txn RD addr=%h data=%h lat=%0d", addr, data, lat);
    endtask

    task automatic wait_inst_valid(output int lat);
        lat = 1;
        while (!Inst_Valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;

        rst             = 1'b1;
        PC              = '0;
        Inst_Req_Valid  = 1'b0;
        Inst_Ready      = 1'b0;
        Address         = '0;
        MemWrite        = 1'b0;
        Write_data      = '0;
        Write_strb      = '0;
        MemRead         = 1'b0;
        Read_data_Ready = 1'b0;

        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0000_00AA, 4'h1, 32'h0};
        vecs[2]  = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 32'hDEAD_BEAA};
        vecs[3]  = '{1'b1, 32'h0000_4000, 32'h0000_0055, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0055};
        vecs[5]  = '{1'b1, 32'h0000_0300, 32'h1122_3344, 4'hF, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0300, 32'hAABB_CCDD, 4'hA, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0301, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[8]  = '{1'b1, 32'h0000_0304, 32'h1234_5678, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0304, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0304, 32'h0,         4'h0, 32'h1234_5678};
        vecs[11] = '{1'b0, 32'hFFFF_C303, 32'h0,         4'h0, 32'hAA22_CC44};

        // Reset held for three cycles.
        tick(); tick(); tick();
        check("rst_inst_req_ready", {31'd0, Inst_Req_Ready}, 32'd0);
        check("rst_mem_req_ready",  {31'd0, Mem_Req_Ready},  32'd0);
        check("rst_inst_valid",     {31'd0, Inst_Valid},     32'd0);
        check("rst_rd_valid",       {31'd0, Read_data_Valid}, 32'd0);
        check("rst_instruction",    Instruction, 32'd0);
        check("rst_read_data",      Read_data,   32'd0);
        rst = 1'b0;
        #1;
        check("init_inst_req_ready", {31'd0, Inst_Req_Ready}, 32'd0);
        tick();
        check("idle_inst_req_ready", {31'd0, Inst_Req_Ready}, 32'd1);
        check("idle_mem_req_ready",  {31'd0, Mem_Req_Ready},  32'd1);
        check("idle_inst_valid",     {31'd0, Inst_Valid},     32'd0);

        // Table-driven writes and reads.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                do_read(vecs[i].addr, rd, lat);
                check($sformatf("vec%0d_data", i), rd, vecs[i].exp);
                check($sformatf("vec%0d_lat", i), lat, 32'd2);
            end
        end

        // Fetch with back-pressure: word 4 preloaded through the data port.
        do_write(32'h0000_0010, 32'h00A0_0093, 4'hF);
        PC = 32'h0000_0010;
        Inst_Req_Valid = 1'b1;
        tick();
        Inst_Req_Valid = 1'b0;
        check("fetch_wait_ready", {31'd0, Inst_Req_Ready}, 32'd0);
        wait_inst_valid(lat);
        check("fetch_lat", lat, 32'd2);
        check("fetch_data", Instruction, 32'h00A0_0093);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("fetch_hold_valid", {31'd0, Inst_Valid}, 32'd1);
            check("fetch_hold_data", Instruction, 32'h00A0_0093);
            check("fetch_hold_ready", {31'd0, Inst_Req_Ready}, 32'd0);
        end
        Inst_Ready = 1'b1;
        tick();
        Inst_Ready = 1'b0;
        check("fetch_done_valid", {31'd0, Inst_Valid}, 32'd0);
        check("fetch_done_ready", {31'd0, Inst_Req_Ready}, 32'd1);
        $display("txn IF pc=%h inst=%h", PC, 32'h00A0_0093);

        // Fetch and data write to the same word on the same edge: old word returned.
        PC = 32'h0000_0010;
        Inst_Req_Valid = 1'b1;
        Address = 32'h0000_0010;
        Write_data = 32'hCAFE_0000;
        Write_strb = 4'hF;
        MemWrite = 1'b1;
        tick();
        Inst_Req_Valid = 1'b0;
        MemWrite = 1'b0;
        wait_inst_valid(lat);
        check("same_cycle_inst", Instruction, 32'h00A0_0093);
        Inst_Ready = 1'b1;
        tick();
        Inst_Ready = 1'b0;
        Inst_Req_Valid = 1'b1;
        tick();
        Inst_Req_Valid = 1'b0;
        wait_inst_valid(lat);
        check("refetch_inst", Instruction, 32'hCAFE_0000);
        Inst_Ready = 1'b1;
        tick();
        Inst_Ready = 1'b0;
        $display("txn IF pc=%h inst=%h", PC, Instruction);

        // Read-before-write hazard: write presented while the read is in flight.
        do_write(32'h0000_0200, 32'h0000_0001, 4'hF);
        Address = 32'h0000_0200;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        Write_data = 32'h0000_0002;
        Write_strb = 4'hF;
        MemWrite = 1'b1;
        check("hazard_busy_ready", {31'd0, Mem_Req_Ready}, 32'd0);
        lat = 1;
        while (!Read_data_Valid && lat < 20) begin
            tick();
            lat++;
        end
        check("hazard_lat", lat, 32'd2);
        check("hazard_old_data", Read_data, 32'h0000_0001);
        Read_data_Ready = 1'b1;
        tick();
        Read_data_Ready = 1'b0;
        wait_mem_ready("hazard_wr_ready");
        tick();
        MemWrite = 1'b0;
        do_read(32'h0000_0200, rd, lat);
        check("hazard_new_data", rd, 32'h0000_0002);

        // MemRead and MemWrite together: write only, no response.
        Address = 32'h0000_0308;
        Write_data = 32'h0000_0077;
        Write_strb = 4'hF;
        MemWrite = 1'b1;
        MemRead = 1'b1;
        tick();
        MemWrite = 1'b0;
        MemRead = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (Read_data_Valid) seen = 1'b1;
            tick();
        end
        check("rdwr_no_resp", {31'd0, seen}, 32'd0);
        do_read(32'h0000_0308, rd, lat);
        check("rdwr_written", rd, 32'h0000_0077);

        // Reset one cycle after a read is accepted.
        Address = 32'h0000_0100;
        MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_init_ready", {31'd0, Mem_Req_Ready}, 32'd0);
        check("midrst_read_data", Read_data, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (Read_data_Valid) seen = 1'b1;
            tick();
        end
        check("midrst_no_valid", {31'd0, seen}, 32'd0);
        do_read(32'h0000_0100, rd, lat);
        check("midrst_after_data", rd, 32'hDEAD_BEAA);
        check("midrst_after_lat", lat, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
